// File: rtl/target_entry_parser.sv
// rtl/target_entry_parser.sv - ASCII keystrokes to packed-BCD target coordinates with queue pulse
// Optional echo write port and CLEAR state: define TARGET_ENTRY_ECHO_EN.
module target_entry_parser (
  input  logic        clock,
  input  logic        resetn,
  input  logic        key_valid,
  input  logic [7:0]  key_ascii,
  output logic [31:0] targetx,
  output logic [31:0] targety,
  output logic        queue,
  output logic [3:0]  digit_count,
  output logic        busy,
  output logic        error
`ifdef TARGET_ENTRY_ECHO_EN
  ,
  output logic        echo_we,
  output logic [7:0]  echo_index,
  output logic [7:0]  echo_data
`endif
);

`ifdef TARGET_ENTRY_ECHO_EN
  typedef enum logic [1:0] {ST_ENTRY, ST_COMMIT, ST_PULSE, ST_CLEAR} state_t;
`else
  typedef enum logic [1:0] {ST_ENTRY, ST_COMMIT, ST_PULSE} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] sx_q, sx_d, sy_q, sy_d;
  logic [31:0] tx_q, tx_d, ty_q, ty_d;
  logic [3:0]  count_q, count_d;
  logic        queue_q, queue_d;
  logic        error_q, error_d;
  logic        is_digit;
  logic [2:0]  pos, bpos;
  logic [4:0]  off, boff;

  assign is_digit = (key_ascii >= 8'h30) && (key_ascii <= 8'h39);
  assign pos      = count_q[2:0];
  assign bpos     = count_q[2:0] - 3'd1;
  // Digit k lands in nibble 3-(k mod 4): byte offset (3-k)*8 is just the inverted low bits.
  assign off      = {~pos[1:0], 3'b000};
  assign boff     = {~bpos[1:0], 3'b000};

`ifdef TARGET_ENTRY_ECHO_EN
  logic [2:0] clr_q, clr_d;
  logic       ew_q, ew_d;
  logic [7:0] ei_q, ei_d, ed_q, ed_d;

  function automatic logic [7:0] echo_map(input logic [2:0] k);
    case (k)
      3'd0:    return 8'd116;
      3'd1:    return 8'd117;
      3'd2:    return 8'd119;
      3'd3:    return 8'd120;
      3'd4:    return 8'd122;
      3'd5:    return 8'd123;
      3'd6:    return 8'd125;
      default: return 8'd126;
    endcase
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    count_d = count_q;
    error_d = 1'b0;
    // Registered so queue rises a full cycle after the targets settle.
    queue_d = (state_q == ST_PULSE);
`ifdef TARGET_ENTRY_ECHO_EN
    clr_d = clr_q;
    ew_d  = 1'b0;
    ei_d  = 8'h00;
    ed_d  = 8'h00;
`endif
    case (state_q)
      ST_ENTRY: begin
        if (key_valid) begin
          if (is_digit) begin
            if (count_q == 4'd8) begin
              error_d = 1'b1;
            end else begin
              if (pos[2]) sy_d[off +: 4] = key_ascii[3:0];
              else        sx_d[off +: 4] = key_ascii[3:0];
              count_d = count_q + 4'd1;
`ifdef TARGET_ENTRY_ECHO_EN
              ew_d = 1'b1;
              ei_d = echo_map(pos);
              ed_d = key_ascii;
`endif
            end
          end else if (key_ascii == 8'h08) begin
            if (count_q != 4'd0) begin
              if (bpos[2]) sy_d[boff +: 4] = 4'h0;
              else         sx_d[boff +: 4] = 4'h0;
              count_d = count_q - 4'd1;
`ifdef TARGET_ENTRY_ECHO_EN
              ew_d = 1'b1;
              ei_d = echo_map(bpos);
              ed_d = 8'h20;
`endif
            end
          end else if (key_ascii == 8'h0D) begin
            if (count_q == 4'd8) begin
              tx_d    = sx_q;
              ty_d    = sy_q;
              sx_d    = 32'h0;
              sy_d    = 32'h0;
              count_d = 4'd0;
              state_d = ST_COMMIT;
            end else begin
              error_d = 1'b1;
            end
          end else if (key_ascii == 8'h1B) begin
            sx_d    = 32'h0;
            sy_d    = 32'h0;
            count_d = 4'd0;
`ifdef TARGET_ENTRY_ECHO_EN
            clr_d   = 3'd0;
            state_d = ST_CLEAR;
`endif
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        error_d = key_valid;
        state_d = ST_PULSE;
      end
      ST_PULSE: begin
        error_d = key_valid;
`ifdef TARGET_ENTRY_ECHO_EN
        clr_d   = 3'd0;
        state_d = ST_CLEAR;
`else
        state_d = ST_ENTRY;
`endif
      end
`ifdef TARGET_ENTRY_ECHO_EN
      ST_CLEAR: begin
        error_d = key_valid;
        clr_d   = clr_q + 3'd1;
        if (clr_q == 3'd7) state_d = ST_ENTRY;
      end
`endif
      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_ENTRY;
      sx_q    <= 32'h0;
      sy_q    <= 32'h0;
      tx_q    <= 32'h0;
      ty_q    <= 32'h0;
      count_q <= 4'd0;
      queue_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      count_q <= count_d;
      queue_q <= queue_d;
      error_q <= error_d;
    end
  end

`ifdef TARGET_ENTRY_ECHO_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clr_q <= 3'd0;
      ew_q  <= 1'b0;
      ei_q  <= 8'h00;
      ed_q  <= 8'h00;
    end else begin
      clr_q <= clr_d;
      ew_q  <= ew_d;
      ei_q  <= ei_d;
      ed_q  <= ed_d;
    end
  end

  // The CLEAR sweep drives the port straight from the state so it stays inside busy.
  assign echo_we    = ew_q | (state_q == ST_CLEAR);
  assign echo_index = (state_q == ST_CLEAR) ? echo_map(clr_q) : ei_q;
  assign echo_data  = (state_q == ST_CLEAR) ? 8'h20 : ed_q;
`endif

  assign targetx     = tx_q;
  assign targety     = ty_q;
  assign queue       = queue_q;
  assign digit_count = count_q;
  assign error       = error_q;
  assign busy        = (state_q != ST_ENTRY);

endmodule

// File: tb/tb_target_entry_parser.sv
// tb/tb_target_entry_parser.sv - table-driven bench with a queue-pulse scoreboard
// Echo checks are compiled when TARGET_ENTRY_ECHO_EN is defined.
module tb_target_entry_parser;
  logic        clock = 1'b0;
  logic        resetn;
  logic        key_valid;
  logic [7:0]  key_ascii;
  logic [31:0] targetx, targety;
  logic        queue, busy, error;
  logic [3:0]  digit_count;
`ifdef TARGET_ENTRY_ECHO_EN
  logic        echo_we;
  logic [7:0]  echo_index, echo_data;
  logic [7:0]  emap [8] = '{8'd116, 8'd117, 8'd119, 8'd120, 8'd122, 8'd123, 8'd125, 8'd126};
`endif

  target_entry_parser dut (
    .clock(clock), .resetn(resetn), .key_valid(key_valid), .key_ascii(key_ascii),
    .targetx(targetx), .targety(targety), .queue(queue), .digit_count(digit_count),
    .busy(busy), .error(error)
`ifdef TARGET_ENTRY_ECHO_EN
    , .echo_we(echo_we), .echo_index(echo_index), .echo_data(echo_data)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  key;
    logic [3:0]  cnt;
    logic        err;
    logic [31:0] tx;
    logic [31:0] ty;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] sb[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] k, input logic [3:0] c, input logic e,
                     input logic [31:0] x, input logic [31:0] y);
    vec_t v;
    v.key = k; v.cnt = c; v.err = e; v.tx = x; v.ty = y;
    vecs.push_back(v);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("idle_after_busy", {31'b0, busy}, 32'd0);
  endtask

  // Scoreboard: each queue pulse must carry the committed coordinates pushed at Enter.
  always @(negedge clock) begin
    if (resetn === 1'b1 && queue === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL queue_unexpected: got pulse expected none");
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("queue_targetx", targetx, e[63:32]);
        chk("queue_targety", targety, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] k;
    resetn    = 1'b0;
    key_valid = 1'b0;
    key_ascii = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_targetx", targetx, 32'h0);
    chk("rst_targety", targety, 32'h0);
    chk("rst_queue", {31'b0, queue}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_count", {28'b0, digit_count}, 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) add(8'h31 + 8'(i), 4'(i + 1), 1'b0, 32'h0, 32'h0);
    add(8'h39, 4'd8, 1'b1, 32'h0, 32'h0);
    add(8'h41, 4'd8, 1'b1, 32'h0, 32'h0);
    add(8'h08, 4'd7, 1'b0, 32'h0, 32'h0);
    add(8'h38, 4'd8, 1'b0, 32'h0, 32'h0);
    add(8'h0D, 4'd0, 1'b0, 32'h01020304, 32'h05060708);
    add(8'h31, 4'd1, 1'b0, 32'h01020304, 32'h05060708);
    add(8'h32, 4'd2, 1'b0, 32'h01020304, 32'h05060708);
    add(8'h08, 4'd1, 1'b0, 32'h01020304, 32'h05060708);
    add(8'h39, 4'd2, 1'b0, 32'h01020304, 32'h05060708);
    add(8'h31, 4'd3, 1'b0, 32'h01020304, 32'h05060708);
    add(8'h0D, 4'd3, 1'b1, 32'h01020304, 32'h05060708);
    for (int i = 0; i < 5; i++) add(8'h32 + 8'(i), 4'(i + 4), 1'b0, 32'h01020304, 32'h05060708);
    add(8'h0D, 4'd0, 1'b0, 32'h01090102, 32'h03040506);
    add(8'h08, 4'd0, 1'b0, 32'h01090102, 32'h03040506);
    add(8'h37, 4'd1, 1'b0, 32'h01090102, 32'h03040506);
    add(8'h2F, 4'd1, 1'b1, 32'h01090102, 32'h03040506);
    add(8'h3A, 4'd1, 1'b1, 32'h01090102, 32'h03040506);
    add(8'h1B, 4'd0, 1'b0, 32'h01090102, 32'h03040506);
    add(8'h33, 4'd1, 1'b0, 32'h01090102, 32'h03040506);
    add(8'h08, 4'd0, 1'b0, 32'h01090102, 32'h03040506);

    foreach (vecs[i]) begin
      @(negedge clock);
      chk($sformatf("r%0d_error_prev", i), {31'b0, error}, 32'd0);
      if (vecs[i].key == 8'h0D && !vecs[i].err) sb.push_back({vecs[i].tx, vecs[i].ty});
      key_valid = 1'b1;
      key_ascii = vecs[i].key;
      @(negedge clock);
      key_valid = 1'b0;
      chk($sformatf("r%0d_count", i), {28'b0, digit_count}, {28'b0, vecs[i].cnt});
      chk($sformatf("r%0d_error", i), {31'b0, error}, {31'b0, vecs[i].err});
      chk($sformatf("r%0d_targetx", i), targetx, vecs[i].tx);
      chk($sformatf("r%0d_targety", i), targety, vecs[i].ty);
      wait_idle();
    end

    // Commit timing, a key dropped during PULSE, then reset while queue is high.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      k = 8'h38 - 8'(i);
      key_valid = 1'b1;
      key_ascii = k;
    end
    @(negedge clock);
    chk("seq_count8", {28'b0, digit_count}, 32'd8);
    sb.push_back({32'h08070605, 32'h04030201});
    key_ascii = 8'h0D;
    @(negedge clock);
    key_valid = 1'b0;
    chk("seq_tx_at_E", targetx, 32'h08070605);
    chk("seq_ty_at_E", targety, 32'h04030201);
    chk("seq_busy_E", {31'b0, busy}, 32'd1);
    chk("seq_queue_E", {31'b0, queue}, 32'd0);
    chk("seq_count_E", {28'b0, digit_count}, 32'd0);
    @(negedge clock);
    chk("seq_queue_E1", {31'b0, queue}, 32'd0);
    chk("seq_busy_E1", {31'b0, busy}, 32'd1);
    key_valid = 1'b1;
    key_ascii = 8'h35;
    @(negedge clock);
    key_valid = 1'b0;
    chk("seq_queue_E2", {31'b0, queue}, 32'd1);
    chk("seq_pulse_drop_error", {31'b0, error}, 32'd1);
    chk("seq_pulse_drop_count", {28'b0, digit_count}, 32'd0);
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_queue", {31'b0, queue}, 32'd0);
    chk("mid_rst_targetx", targetx, 32'h0);
    chk("mid_rst_targety", targety, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_error", {31'b0, error}, 32'd0);
    chk("mid_rst_count", {28'b0, digit_count}, 32'd0);
`ifdef TARGET_ENTRY_ECHO_EN
    chk("mid_rst_echo_we", {31'b0, echo_we}, 32'd0);
`endif
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("post_rst_queue", {31'b0, queue}, 32'd0);

`ifdef TARGET_ENTRY_ECHO_EN
    key_valid = 1'b1;
    key_ascii = 8'h34;
    @(negedge clock);
    key_valid = 1'b0;
    chk("echo_digit_we", {31'b0, echo_we}, 32'd1);
    chk("echo_digit_index", {24'b0, echo_index}, 32'd116);
    chk("echo_digit_data", {24'b0, echo_data}, 32'h34);
    key_valid = 1'b1;
    key_ascii = 8'h1B;
    @(negedge clock);
    key_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("clr%0d_we", i), {31'b0, echo_we}, 32'd1);
      chk($sformatf("clr%0d_busy", i), {31'b0, busy}, 32'd1);
      chk($sformatf("clr%0d_index", i), {24'b0, echo_index}, {24'b0, emap[i]});
      chk($sformatf("clr%0d_data", i), {24'b0, echo_data}, 32'h20);
      @(negedge clock);
    end
    chk("clr_done_busy", {31'b0, busy}, 32'd0);
    chk("clr_done_we", {31'b0, echo_we}, 32'd0);
    chk("clr_done_count", {28'b0, digit_count}, 32'd0);
`endif

    repeat (4) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/target_entry_parser.md
# target_entry_parser

Keyboard-side decoder for manual target entry: consumes ASCII keystrokes from the PS/2 front end, parses four X and four Y decimal digits into the packed-BCD coordinate format used by the target-list printer, and issues the `queue` pulse that stores the entry. It is the inverse of the printer's number-to-ASCII path. It sits between the PS/2 ASCII decoder and the printer's `targetx`/`targety`/`queue` inputs.

## Interface
- Parameters: none.
- `clock`  in  1  system clock; all state changes on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle strobe; `key_ascii` valid this cycle.
- `key_ascii`  in  8  ASCII code of the keystroke.
- `targetx`  out  32  committed X coordinate; BCD digits at [27:24],[19:16],[11:8],[3:0] (most to least significant); all other bits 0.
- `targety`  out  32  committed Y coordinate; same layout.
- `queue`  out  1  one-cycle store pulse to the printer.
- `digit_count`  out  4  digits held in the shadow entry, 0..8.
- `busy`  out  1  high while in COMMIT, PULSE or CLEAR.
- `error`  out  1  one-cycle pulse on a rejected keystroke.
- `echo_we`, `echo_index[7:0]`, `echo_data[7:0]`  out  echo write port (ECHO_EN only).

## Operation
- Shadow registers `sx`, `sy` (same layout as outputs) plus `digit_count`. Digit k (0-based, k<4) goes to `sx` nibble 3-k; digits 4..7 go to `sy` nibble 7-k.
- States: ENTRY, COMMIT, PULSE, CLEAR (CLEAR exists only with ECHO_EN).
- ENTRY, on `key_valid`:
  - 0x30..0x39 with count<8: store `key_ascii[3:0]` at position count; count+1.
  - 0x30..0x39 with count=8: `error`.
  - 0x08 (backspace): count>0 -> count-1, that nibble cleared to 0; count=0 -> ignored, no error.
  - 0x0D (enter): count=8 -> `targetx`<=`sx`, `targety`<=`sy`, shadow cleared, count<=0, go COMMIT; count<8 -> `error`, no change.
  - 0x1B (escape): shadow and count cleared; go CLEAR with ECHO_EN, stay in ENTRY without it.
  - Any other code: `error`.
- COMMIT: one cycle, then PULSE. PULSE: `queue`=1 for that cycle, then ENTRY.
- `key_valid` while `busy`=1: keystroke dropped, `error` pulsed.
- Counts never wrap: count stays in 0..8.

## Timing
- Reset (`resetn`=0, asynchronous): `targetx`=`targety`=0, shadow=0, count=0, `queue`=0, `error`=0, `busy`=0, echo outputs 0, state ENTRY. Reset mid-entry or mid-PULSE discards everything, and `queue` drops immediately.
- Enter accepted at edge E: `targetx`/`targety` update at E; `queue` high from E+2 to E+3. This guarantees the printer's registered copy is stable before the `queue` rising edge.
- `error` is high for exactly the cycle after the offending edge.
- `targetx`/`targety` change only on commit and hold otherwise.

## Configuration
- `TARGET_ENTRY_ECHO_EN` defined: echo port present.
  - Accepted digit k: `echo_we`=1 for one cycle, `echo_index`=map[k], `echo_data`=`key_ascii`. map = 116,117,119,120,122,123,125,126.
  - Backspace: writes 0x20 at map[new count].
  - Escape, and the COMMIT state: enter CLEAR, which writes 0x20 to map[0..7] on 8 consecutive cycles with `busy`=1. After a commit, CLEAR runs after PULSE.
  - `echo_we` otherwise 0.
- Undefined: echo ports absent, no CLEAR state, escape takes effect in one cycle.

## Test plan
- Reset, then keys "1234","5678", Enter -> `targetx`=0x01020304, `targety`=0x05060708 at E; `queue` single pulse at E+2; count=0.
- "12", backspace, "9" -> shadow X nibbles [27:24]=1, [19:16]=9; count=2; no `error`.
- "123", Enter -> `error` one cycle, outputs unchanged, count=3.
- Nine digits -> ninth gives `error`; 'A' (0x41) gives `error`; a key during PULSE is dropped with `error`.
- ECHO_EN: "4" -> `echo_we`, index 116, data 0x34; escape -> spaces written to 116..126 over 8 cycles, `busy` high throughout.
- Assert `resetn` low during PULSE -> `queue` drops immediately; all outputs 0.
